rom_dl_sequencer: RTL and testbench

- Sequences MiSTer ioctl ROM downloads into the core's storage resources:
  - SDRAM port1 for the CPU1/CPU2 image and everything above it.
  - SDRAM port2 for graphics rebased at 0x30000.
  - Sound dual-port RAM.
  - Colour/height PROM bus.
  - DIP switch bytes.
  - core_mod register.
- Replaces the ad-hoc toggle logic and reset stretcher in the emu top level with one handshaked controller.
- Produces rom_loaded and the stretched core reset.

---
 rtl/rom_dl_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_rom_dl_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dl_sequencer.sv
// ioctl ROM download sequencer: routes download bytes to SDRAM ports 1/2, sound RAM,
// PROM, DIP and core_mod registers, and generates rom_loaded plus the stretched core reset.
module rom_dl_sequencer #(
  parameter logic [24:0] SND_BASE   = 25'h20000,
  parameter logic [24:0] GFX_BASE   = 25'h30000,
  parameter logic [24:0] PROM_BASE  = 25'hA0000,
  parameter logic [15:0] RST_CYCLES = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic [7:0]  ioctl_index,
  input  logic        reset_req,
  output logic        p1_req,
  input  logic        p1_ack,
  output logic        p2_req,
  input  logic        p2_ack,
  output logic [22:0] p1_a,
  output logic [22:0] p2_a,
  output logic [1:0]  p_ds,
  output logic [15:0] p_d,
  output logic        p_we,
  output logic        snd_wr,
  output logic [15:0] snd_addr,
  output logic [7:0]  snd_data,
  output logic        prom_wr,
  output logic [11:0] prom_addr,
  output logic [7:0]  prom_data,
  output logic [7:0]  core_mod,
  output logic [63:0] dip,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic        wr_prev_q, dl_prev_q;
  logic        hold_valid_q, hold_valid_d;
  logic [24:0] hold_addr_q, hold_addr_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic        p1_req_q, p1_req_d, p2_req_q, p2_req_d, p2_sel_q, p2_sel_d;
  logic [22:0] p1_a_q, p1_a_d, p2_a_q, p2_a_d;
  logic [1:0]  p_ds_q, p_ds_d;
  logic [15:0] p_d_q, p_d_d;
  logic        snd_wr_q, snd_wr_d, prom_wr_q, prom_wr_d;
  logic [15:0] snd_addr_q, snd_addr_d;
  logic [7:0]  snd_data_q, snd_data_d;
  logic [11:0] prom_addr_q, prom_addr_d;
  logic [7:0]  prom_data_q, prom_data_d;
  logic [7:0]  core_mod_q, core_mod_d;
  logic [63:0] dip_q, dip_d;
  logic        rom_loaded_q, rom_loaded_d, overflow_q, overflow_d;
  logic [15:0] rst_cnt_q, rst_cnt_d;
  logic        core_reset_q, core_reset_d;

  logic cap, rom_cap, consume, in_snd, in_prom;

  assign cap     = ioctl_wr & ~wr_prev_q;
  assign rom_cap = cap & ioctl_download & (ioctl_index == 8'd0);
  assign in_snd  = (ioctl_addr >= SND_BASE) && (ioctl_addr <= SND_BASE + 25'h0FFFF);
  assign in_prom = (ioctl_addr >= PROM_BASE) && (ioctl_addr <= PROM_BASE + 25'h0091F);

  always_comb begin
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    p1_req_d     = p1_req_q;
    p2_req_d     = p2_req_q;
    p2_sel_d     = p2_sel_q;
    p1_a_d       = p1_a_q;
    p2_a_d       = p2_a_q;
    p_ds_d       = p_ds_q;
    p_d_d        = p_d_q;
    snd_addr_d   = snd_addr_q;
    snd_data_d   = snd_data_q;
    prom_addr_d  = prom_addr_q;
    prom_data_d  = prom_data_q;
    core_mod_d   = core_mod_q;
    dip_d        = dip_q;
    rom_loaded_d = rom_loaded_q;
    overflow_d   = overflow_q;
    rst_cnt_d    = rst_cnt_q;
    consume      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_valid_q) begin
          p1_a_d   = hold_addr_q[23:1];
          p2_a_d   = hold_addr_q[23:1] - GFX_BASE[23:1];
          p_ds_d   = {hold_addr_q[0], ~hold_addr_q[0]};
          p_d_d    = {hold_data_q, hold_data_q};
          p2_sel_d = (hold_addr_q >= GFX_BASE);
          consume  = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        p1_req_d = ~p1_req_q;
        if (p2_sel_q) p2_req_d = ~p2_req_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if ((p1_ack == p1_req_q) && (!p2_sel_q || (p2_ack == p2_req_q))) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A capture in the same cycle as the IDLE consume replaces the byte just taken, so it is not lost.
    if (rom_cap) begin
      hold_addr_d  = ioctl_addr;
      hold_data_d  = ioctl_dout;
      hold_valid_d = 1'b1;
      if (hold_valid_q && !consume) overflow_d = 1'b1;
    end else if (consume) begin
      hold_valid_d = 1'b0;
    end

    snd_wr_d  = rom_cap & in_snd;
    prom_wr_d = rom_cap & in_prom;
    if (snd_wr_d) begin
      snd_addr_d = ioctl_addr[15:0] - SND_BASE[15:0];
      snd_data_d = ioctl_dout;
    end
    if (prom_wr_d) begin
      prom_addr_d = ioctl_addr[11:0] - PROM_BASE[11:0];
      prom_data_d = ioctl_dout;
    end

    if (cap && ioctl_index == 8'd1) core_mod_d = ioctl_dout;
    if (cap && ioctl_index == 8'd254 && ioctl_addr[24:3] == '0)
      dip_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;

    if (dl_prev_q && !ioctl_download && ioctl_index == 8'd0) rom_loaded_d = 1'b1;

    if (reset_req || !rom_loaded_q || state_q != S_IDLE || hold_valid_q) rst_cnt_d = RST_CYCLES;
    else if (rst_cnt_q != '0) rst_cnt_d = rst_cnt_q - 16'd1;
    core_reset_d = (rst_cnt_q != '0);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wr_prev_q    <= 1'b0;
      dl_prev_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      p1_req_q     <= 1'b0;
      p2_req_q     <= 1'b0;
      p2_sel_q     <= 1'b0;
      p1_a_q       <= '0;
      p2_a_q       <= '0;
      p_ds_q       <= '0;
      p_d_q        <= '0;
      snd_wr_q     <= 1'b0;
      snd_addr_q   <= '0;
      snd_data_q   <= '0;
      prom_wr_q    <= 1'b0;
      prom_addr_q  <= '0;
      prom_data_q  <= '0;
      core_mod_q   <= '0;
      dip_q        <= '0;
      rom_loaded_q <= 1'b0;
      overflow_q   <= 1'b0;
      rst_cnt_q    <= RST_CYCLES;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_prev_q    <= ioctl_wr;
      dl_prev_q    <= ioctl_download;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      p1_req_q     <= p1_req_d;
      p2_req_q     <= p2_req_d;
      p2_sel_q     <= p2_sel_d;
      p1_a_q       <= p1_a_d;
      p2_a_q       <= p2_a_d;
      p_ds_q       <= p_ds_d;
      p_d_q        <= p_d_d;
      snd_wr_q     <= snd_wr_d;
      snd_addr_q   <= snd_addr_d;
      snd_data_q   <= snd_data_d;
      prom_wr_q    <= prom_wr_d;
      prom_addr_q  <= prom_addr_d;
      prom_data_q  <= prom_data_d;
      core_mod_q   <= core_mod_d;
      dip_q        <= dip_d;
      rom_loaded_q <= rom_loaded_d;
      overflow_q   <= overflow_d;
      rst_cnt_q    <= rst_cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign p1_req     = p1_req_q;
  assign p2_req     = p2_req_q;
  assign p1_a       = p1_a_q;
  assign p2_a       = p2_a_q;
  assign p_ds       = p_ds_q;
  assign p_d        = p_d_q;
  assign p_we       = ioctl_download & (ioctl_index == 8'd0);
  assign snd_wr     = snd_wr_q;
  assign snd_addr   = snd_addr_q;
  assign snd_data   = snd_data_q;
  assign prom_wr    = prom_wr_q;
  assign prom_addr  = prom_addr_q;
  assign prom_data  = prom_data_q;
  assign core_mod   = core_mod_q;
  assign dip        = dip_q;
  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rom_dl_sequencer.sv
// Scoreboard bench for rom_dl_sequencer: expected SDRAM requests are queued per strobe
// and compared when the request toggles appear; side outputs are checked inline.
module tb_rom_dl_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [7:0]  ioctl_index = '0;
  logic        reset_req = 1'b0;
  logic        p1_ack = 1'b0;
  logic        p2_ack = 1'b0;
  logic        p1_req, p2_req, p_we, snd_wr, prom_wr, rom_loaded, core_reset, overflow;
  logic [22:0] p1_a, p2_a;
  logic [1:0]  p_ds;
  logic [15:0] p_d, snd_addr;
  logic [7:0]  snd_data, prom_data, core_mod;
  logic [11:0] prom_addr;
  logic [63:0] dip;

  int checks = 0;
  int errors = 0;
  int n_push = 0;
  bit hold_p1 = 1'b0;
  bit hold_p2 = 1'b0;

  typedef struct packed {
    logic [22:0] p1_a;
    logic [22:0] p2_a;
    logic [1:0]  ds;
    logic [15:0] d;
    logic        p2;
  } req_t;
  req_t exp_q[$];

  rom_dl_sequencer #(.RST_CYCLES(16'd16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_index(ioctl_index), .reset_req(reset_req),
    .p1_req(p1_req), .p1_ack(p1_ack), .p2_req(p2_req), .p2_ack(p2_ack),
    .p1_a(p1_a), .p2_a(p2_a), .p_ds(p_ds), .p_d(p_d), .p_we(p_we),
    .snd_wr(snd_wr), .snd_addr(snd_addr), .snd_data(snd_data),
    .prom_wr(prom_wr), .prom_addr(prom_addr), .prom_data(prom_data),
    .core_mod(core_mod), .dip(dip), .rom_loaded(rom_loaded),
    .core_reset(core_reset), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic req_t model(input logic [24:0] a, input logic [7:0] d);
    req_t r;
    logic [24:0] off;
    off    = a - 25'h30000;
    r.p1_a = a[23:1];
    r.p2   = (a >= 25'h30000);
    r.p2_a = off[23:1];
    r.ds   = {a[0], ~a[0]};
    r.d    = {d, d};
    return r;
  endfunction

  task automatic push(input logic [24:0] a, input logic [7:0] d);
    exp_q.push_back(model(a, d));
    n_push++;
  endtask

  task automatic strobe(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    @(negedge clk_sys);
    ioctl_wr    = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_q.size() != 0 || p1_ack !== p1_req || p2_ack !== p2_req) && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL quiet_timeout pending=%0d p1_req=%b p1_ack=%b p2_req=%b p2_ack=%b",
               exp_q.size(), p1_req, p1_ack, p2_req, p2_ack);
    end
    repeat (3) @(negedge clk_sys);
  endtask

  // SDRAM ack responder: echoes each req toggle after 4 cycles unless held.
  initial begin
    int c1 = 0;
    int c2 = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        c1 = 0; c2 = 0;
      end else begin
        if (p1_req !== p1_ack && !hold_p1) begin
          c1++;
          if (c1 >= 4) begin p1_ack = p1_req; c1 = 0; end
        end else c1 = 0;
        if (p2_req !== p2_ack && !hold_p2) begin
          c2++;
          if (c2 >= 4) begin p2_ack = p2_req; c2 = 0; end
        end else c2 = 0;
      end
    end
  end

  // Scoreboard monitor: each port1 toggle pops one expected request.
  initial begin
    logic p1_prev = 1'b0;
    logic p2_prev = 1'b0;
    req_t r;
    forever begin
      @(negedge clk_sys);
      if (reset_n) begin
        if (p1_req !== p1_prev) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_unexpected p1_a=%h p_ds=%b p_d=%h", p1_a, p_ds, p_d);
          end else begin
            r = exp_q.pop_front();
            checks++;
            if ({p1_a, p_ds, p_d} !== {r.p1_a, r.ds, r.d}) begin
              errors++;
              $display("FAIL sb_p1 got p1_a=%h p_ds=%b p_d=%h want p1_a=%h p_ds=%b p_d=%h",
                       p1_a, p_ds, p_d, r.p1_a, r.ds, r.d);
            end
            checks++;
            if ((p2_req !== p2_prev) !== r.p2) begin
              errors++;
              $display("FAIL sb_p2_toggle got %b want %b", (p2_req !== p2_prev), r.p2);
            end
            if (r.p2) begin
              checks++;
              if (p2_a !== r.p2_a) begin
                errors++;
                $display("FAIL sb_p2_a got %h want %h", p2_a, r.p2_a);
              end
            end
          end
        end else if (p2_req !== p2_prev) begin
          checks++; errors++;
          $display("FAIL sb_p2_alone p2_req=%b without port1 request", p2_req);
        end
      end
      p1_prev = p1_req;
      p2_prev = p2_req;
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({core_reset, p1_req, p2_req, rom_loaded, overflow} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got cr/p1/p2/rl/ov=%b want 10000",
               {core_reset, p1_req, p2_req, rom_loaded, overflow});
    end
    checks++;
    if (core_mod !== 8'h00 || dip !== 64'h0) begin
      errors++;
      $display("FAIL reset_regs got core_mod=%h dip=%h want 0", core_mod, dip);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_index_regs();
    strobe(8'd1, 25'h0, 8'h0B);
    checks++;
    if (core_mod !== 8'h0B) begin errors++; $display("FAIL core_mod got %h want 0b", core_mod); end
    strobe(8'd254, 25'h3, 8'hC4);
    checks++;
    if (dip !== 64'h00000000_C4000000) begin errors++; $display("FAIL dip_byte3 got %h want 00000000c4000000", dip); end
    strobe(8'd254, 25'h8, 8'h11);
    strobe(8'd0, 25'h40, 8'h22);
    repeat (5) @(negedge clk_sys);
    checks++;
    if (dip !== 64'h00000000_C4000000) begin errors++; $display("FAIL dip_out_of_range got %h want 00000000c4000000", dip); end
    checks++;
    if (p1_req !== 1'b0 || p2_req !== 1'b0 || p_we !== 1'b0) begin
      errors++;
      $display("FAIL no_sdram_req got p1=%b p2=%b p_we=%b want 000", p1_req, p2_req, p_we);
    end
  endtask

  task automatic test_rom_p1();
    @(negedge clk_sys);
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    #1;
    checks++;
    if (p_we !== 1'b1) begin errors++; $display("FAIL p_we got %b want 1", p_we); end
    push(25'h00001, 8'h5A);
    strobe(8'd0, 25'h00001, 8'h5A);
    @(negedge clk_sys);
    checks++;
    if (p1_req !== 1'b0) begin errors++; $display("FAIL p1_latency1 got %b want 0", p1_req); end
    @(negedge clk_sys);
    checks++;
    if (p1_req !== 1'b1 || p2_req !== 1'b0) begin
      errors++;
      $display("FAIL p1_latency2 got p1=%b p2=%b want p1=1 p2=0", p1_req, p2_req);
    end
    wait_quiet();
  endtask

  task automatic test_gfx_dual_ack();
    hold_p2 = 1'b1;
    push(25'h30002, 8'h33);
    strobe(8'd0, 25'h30002, 8'h33);
    repeat (10) @(negedge clk_sys);
    push(25'h00010, 8'h44);
    strobe(8'd0, 25'h00010, 8'h44);
    repeat (8) @(negedge clk_sys);
    checks++;
    if (p1_req !== 1'((n_push - 1) % 2)) begin
      errors++;
      $display("FAIL wait_both_acks got p1_req=%b want %b", p1_req, 1'((n_push - 1) % 2));
    end
    hold_p2 = 1'b0;
    wait_quiet();
  endtask

  task automatic test_snd_prom();
    push(25'h2ABCD, 8'h77);
    strobe(8'd0, 25'h2ABCD, 8'h77);
    checks++;
    if ({snd_wr, snd_addr, snd_data} !== {1'b1, 16'hABCD, 8'h77}) begin
      errors++;
      $display("FAIL snd_write got wr=%b addr=%h data=%h want 1 abcd 77", snd_wr, snd_addr, snd_data);
    end
    @(negedge clk_sys);
    checks++;
    if (snd_wr !== 1'b0) begin errors++; $display("FAIL snd_pulse got %b want 0", snd_wr); end
    wait_quiet();
    push(25'hA0905, 8'h99);
    strobe(8'd0, 25'hA0905, 8'h99);
    checks++;
    if ({prom_wr, prom_addr, prom_data, snd_wr} !== {1'b1, 12'h905, 8'h99, 1'b0}) begin
      errors++;
      $display("FAIL prom_write got wr=%b addr=%h data=%h snd_wr=%b want 1 905 99 0",
               prom_wr, prom_addr, prom_data, snd_wr);
    end
    @(negedge clk_sys);
    checks++;
    if (prom_wr !== 1'b0) begin errors++; $display("FAIL prom_pulse got %b want 0", prom_wr); end
    wait_quiet();
    push(25'hA0920, 8'h12);
    strobe(8'd0, 25'hA0920, 8'h12);
    checks++;
    if (prom_wr !== 1'b0 || snd_wr !== 1'b0) begin
      errors++;
      $display("FAIL prom_bound got prom_wr=%b snd_wr=%b want 0 0", prom_wr, snd_wr);
    end
    wait_quiet();
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    hold_p1 = 1'b1;
    push(25'h00100, 8'h01);
    strobe(8'd0, 25'h00100, 8'h01);
    strobe(8'd0, 25'h00102, 8'h02);
    push(25'h00104, 8'h03);
    strobe(8'd0, 25'h00104, 8'h03);
    @(negedge clk_sys);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b want 1", overflow); end
    repeat (4) @(negedge clk_sys);
    hold_p1 = 1'b0;
    wait_quiet();
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b want 1", overflow); end
  endtask

  task automatic test_end_download();
    int k;
    checks++;
    if (core_reset !== 1'b1 || rom_loaded !== 1'b0) begin
      errors++;
      $display("FAIL pre_end got core_reset=%b rom_loaded=%b want 1 0", core_reset, rom_loaded);
    end
    hold_p1 = 1'b1;
    push(25'h00020, 8'h55);
    strobe(8'd0, 25'h00020, 8'h55);
    repeat (4) @(negedge clk_sys);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (rom_loaded !== 1'b1) begin errors++; $display("FAIL rom_loaded got %b want 1", rom_loaded); end
    repeat (5) @(negedge clk_sys);
    checks++;
    if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_held_in_wait got %b want 1", core_reset); end
    p1_ack = p1_req;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk_sys);
      if (core_reset === 1'b0) break;
    end
    checks++;
    if (k - 1 != 17) begin errors++; $display("FAIL reset_release got %0d cycles want 17", k - 1); end
    hold_p1 = 1'b0;
  endtask

  task automatic test_reset_req();
    int k;
    @(negedge clk_sys);
    reset_req = 1'b1;
    repeat (3) @(negedge clk_sys);
    checks++;
    if (core_reset !== 1'b1) begin errors++; $display("FAIL reset_req_assert got %b want 1", core_reset); end
    reset_req = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk_sys);
      if (core_reset === 1'b0) break;
    end
    checks++;
    if (k - 1 != 16) begin errors++; $display("FAIL reset_req_stretch got %0d cycles want 16", k - 1); end
  endtask

  task automatic test_async_reset();
    @(negedge clk_sys);
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    hold_p1 = 1'b1;
    push(25'h00040, 8'h66);
    strobe(8'd0, 25'h00040, 8'h66);
    repeat (3) @(negedge clk_sys);
    checks++;
    if (p1_req !== 1'(n_push % 2)) begin
      errors++;
      $display("FAIL pre_async_p1 got %b want %b", p1_req, 1'(n_push % 2));
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({p1_req, p2_req, rom_loaded, overflow, core_reset} !== 5'b00001) begin
      errors++;
      $display("FAIL async_reset got p1/p2/rl/ov/cr=%b want 00001",
               {p1_req, p2_req, rom_loaded, overflow, core_reset});
    end
    p1_ack = 1'b0;
    p2_ack = 1'b0;
    hold_p1 = 1'b0;
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_index_regs();
    test_rom_p1();
    test_gfx_dual_ack();
    test_snd_prom();
    test_overflow();
    test_end_download();
    test_reset_req();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
